// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: state encoding, word/jump geometry and reset PC.
package cpu_pkg;
  localparam int unsigned WORD_BYTES       = 4;
  localparam int unsigned JUMP_TGT_W       = 26;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: jump > taken branch > sequential.
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [31:0]           i_pc,
  input  logic [31:0]           i_branch_offset,
  input  logic [JUMP_TGT_W-1:0] i_jump_target,
  input  logic                  i_branch_taken,
  input  logic                  i_jump,
  output logic [31:0]           o_next_pc,
  output logic [31:0]           o_pc_plus4
);
  logic [31:0] w_pc_plus4;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_jump_tgt;

  assign w_pc_plus4   = i_pc + 32'(WORD_BYTES);
  // Word offset scaled to bytes; wraps naturally so negative offsets step back.
  assign w_branch_tgt = w_pc_plus4 + {i_branch_offset[29:0], 2'b00};
  assign w_jump_tgt   = {w_pc_plus4[31:28], i_jump_target, 2'b00};
  assign o_pc_plus4   = w_pc_plus4;

  always_comb begin
    o_next_pc = w_pc_plus4;
    if (i_jump)
      o_next_pc = w_jump_tgt;
    else if (i_branch_taken)
      o_next_pc = w_branch_tgt;
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word, holds it until the
// processor accepts it, then redirects or advances.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [31:0]           imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instruction,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_offset,
  input  logic                  jump,
  input  logic [JUMP_TGT_W-1:0] jump_target,
  output logic [31:0]           pc,
  output logic [31:0]           pc_plus4,
  output logic [CNT_W-1:0]      instr_count
);
  fetch_state_e     r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      w_next_pc;
  logic [31:0]      w_pc_plus4;

  pc_next_calc u_pc_next_calc (
    .i_pc            (r_pc),
    .i_branch_offset (branch_offset),
    .i_jump_target   (jump_target),
    .i_branch_taken  (branch_taken),
    .i_jump          (jump),
    .o_next_pc       (w_next_pc),
    .o_pc_plus4      (w_pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          // Redirect inputs matter only on the accepting cycle.
          if (instr_ready) begin
            r_pc    <= w_next_pc;
            r_count <= r_count + CNT_W'(1);
            r_state <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign imem_req    = (r_state == FETCH) && !reset;
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == HOLD);
  assign instruction = r_instr;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr_count = r_count;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, reset1;
  logic        imem_ack, instr_ready, branch_taken, jump;
  logic [31:0] imem_rdata, branch_offset;
  logic [25:0] jump_target;

  logic        req0, valid0, req1, valid1;
  logic [31:0] addr0, instr0, pc0, pc4_0, cnt0;
  logic [31:0] addr1, instr1, pc1, pc4_1, cnt1;

  int checks   = 0;
  int failures = 0;

  // Model of the default-reset instance: is a word held, which word, PC, count.
  bit          m_valid;
  logic [31:0] m_pc, m_instr, m_cnt;

  always #5 clk = ~clk;

  instr_fetch_unit dut0 (
    .clk(clk), .reset(reset), .imem_req(req0), .imem_addr(addr0),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instr0),
    .instr_valid(valid0), .instr_ready(instr_ready), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
    .pc(pc0), .pc_plus4(pc4_0), .instr_count(cnt0)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .reset(reset1), .imem_req(req1), .imem_addr(addr1),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instr1),
    .instr_valid(valid1), .instr_ready(instr_ready), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
    .pc(pc1), .pc_plus4(pc4_1), .instr_count(cnt1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [31:0] seq;
    if (reset) begin
      m_valid = 1'b0; m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0;
    end else if (!m_valid) begin
      if (imem_ack) begin
        m_instr = imem_rdata;
        m_valid = 1'b1;
      end
    end else if (instr_ready) begin
      seq = m_pc + 32'd4;
      if (jump)
        m_pc = (seq & 32'hF000_0000) | ({6'd0, jump_target} * 32'd4);
      else if (branch_taken)
        m_pc = seq + branch_offset * 32'd4;
      else
        m_pc = seq;
      m_cnt   = m_cnt + 32'd1;
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_model();
    chk("req",      32'(req0),   32'(!m_valid && !reset));
    chk("addr",     addr0,       m_pc);
    chk("valid",    32'(valid0), 32'(m_valid));
    chk("pc",       pc0,         m_pc);
    chk("pc_plus4", pc4_0,       m_pc + 32'd4);
    chk("count",    cnt0,        m_cnt);
    if (m_valid) chk("instruction", instr0, m_instr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_model();
  endtask

  task automatic clear_ctl();
    imem_ack = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_offset = 32'h0; jump_target = 26'h0;
  endtask

  task automatic fetch_accept(input logic br, input logic [31:0] off,
                              input logic j, input logic [25:0] jt);
    clear_ctl();
    imem_ack = 1'b1; imem_rdata = $urandom;
    tick();
    clear_ctl();
    branch_taken = br; branch_offset = off; jump = j; jump_target = jt;
    instr_ready = 1'b1;
    tick();
    clear_ctl();
  endtask

  initial begin
    reset = 1'b1; reset1 = 1'b1; imem_rdata = 32'h0;
    clear_ctl();
    m_valid = 1'b0; m_pc = 32'h0; m_instr = 32'h0; m_cnt = 32'h0;
    tick(); tick();
    chk("rst_pc", pc0, 32'h0);
    chk("rst_cnt", cnt0, 32'h0);

    // Reset release, immediate ack, immediate accept
    reset = 1'b0; #1;
    chk("first_req", 32'(req0), 32'd1);
    chk("first_addr", addr0, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h8C01_0004;
    tick();
    chk("t1_valid", 32'(valid0), 32'd1);
    chk("t1_instr", instr0, 32'h8C01_0004);
    imem_ack = 1'b0; instr_ready = 1'b1;
    tick();
    chk("t1_addr", addr0, 32'h4);
    chk("t1_cnt", cnt0, 32'd1);

    // Slow memory, then stalled processor
    instr_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("t2_wait_addr", addr0, 32'h4);
      chk("t2_wait_req", 32'(req0), 32'd1);
    end
    imem_ack = 1'b1; imem_rdata = 32'h0123_4567;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'hFFFF_0000;
    repeat (2) begin
      tick();
      chk("t2_hold_cnt", cnt0, 32'd1);
      chk("t2_hold_instr", instr0, 32'h0123_4567);
      chk("t2_hold_pc", pc0, 32'h4);
    end
    instr_ready = 1'b1;
    tick();
    chk("t2_addr", addr0, 32'h8);
    chk("t2_cnt", cnt0, 32'd2);
    clear_ctl();

    // Branches from 0x10
    fetch_accept(1'b0, 32'h0, 1'b0, 26'h0);
    fetch_accept(1'b0, 32'h0, 1'b0, 26'h0);
    chk("t3_at10", addr0, 32'h10);
    fetch_accept(1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0);
    chk("t3_back", addr0, 32'h0000_000C);
    fetch_accept(1'b0, 32'h0, 1'b0, 26'h0);
    chk("t3_at10b", addr0, 32'h10);
    fetch_accept(1'b1, 32'd3, 1'b0, 26'h0);
    chk("t3_fwd", addr0, 32'h0000_0020);

    // Jump beats branch at 0x4000_0000
    fetch_accept(1'b1, 32'h0FFF_FFF7, 1'b0, 26'h0);
    chk("t4_at4000", addr0, 32'h4000_0000);
    fetch_accept(1'b1, 32'h0000_0005, 1'b1, 26'h000_0040);
    chk("t4_jump", addr0, 32'h4000_0100);

    // Reset coinciding with ack in FETCH
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    chk("t5a_valid", 32'(valid0), 32'd0);
    chk("t5a_pc", pc0, 32'h0);
    chk("t5a_cnt", cnt0, 32'd0);
    chk("t5a_instr", instr0, 32'h0);
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
    tick();
    // Reset coinciding with ready in HOLD
    reset = 1'b1; imem_ack = 1'b0; instr_ready = 1'b1;
    tick();
    chk("t5b_valid", 32'(valid0), 32'd0);
    chk("t5b_pc", pc0, 32'h0);
    chk("t5b_cnt", cnt0, 32'd0);
    reset = 1'b0; clear_ctl();

    // High reset PC wraps; stray ack in HOLD is dropped
    reset1 = 1'b0; #1;
    chk("t6_req", 32'(req1), 32'd1);
    chk("t6_addr", addr1, 32'hFFFF_FFFC);
    chk("t6_pc4", pc4_1, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hA5A5_0001;
    tick();
    chk("t6_instr", instr1, 32'hA5A5_0001);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("t6_stray", instr1, 32'hA5A5_0001);
    chk("t6_valid", 32'(valid1), 32'd1);
    imem_ack = 1'b0; instr_ready = 1'b1;
    tick();
    chk("t6_wrap", addr1, 32'h0);
    chk("t6_cnt", cnt1, 32'd1);
    reset1 = 1'b1; clear_ctl();

    // Randomized traffic against the model
    repeat (4000) begin
      reset        = ($urandom_range(0, 63) == 0);
      imem_ack     = 1'($urandom_range(0, 1));
      imem_rdata   = $urandom;
      instr_ready  = 1'($urandom_range(0, 1));
      branch_taken = ($urandom_range(0, 2) == 0);
      jump         = ($urandom_range(0, 3) == 0);
      branch_offset = ($urandom_range(0, 1) == 1) ? ($urandom_range(0, 63) - 32'd32) : $urandom;
      jump_target  = 26'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
